// File: rtl/demux_8_reg_pkg.sv
// Shared constants for the 8-channel demux/mux pair: channel count, select width
// and the select-to-strobe decode.
package demux_8_reg_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a valid bit for a single demux channel.
// Per-cycle priority: reset > flush > load > drain > hold.
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            // Flush only drops validity; the stale word stays in place.
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= data_in;
        end else if (ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid    = r_valid;
    assign data_out = r_data;

endmodule

// File: rtl/demux_8_reg.sv
// Registered 1-to-8 demultiplexer: each accepted word lands in the holding slot
// named by in_sel; only that slot's occupancy can back-pressure the input.
module demux_8_reg
    import demux_8_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data
);

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_load;
    logic              w_accept;

    // A slot can take a word when empty or when its consumer drains it this cycle.
    assign in_ready = ~flush & (~w_valid[in_sel] | out_ready[in_sel]);
    assign w_accept = in_valid & in_ready;

    // Gating with in_valid keeps an undriven in_sel out of the slot state.
    assign w_load    = w_accept ? sel_onehot(in_sel) : '0;
    assign out_valid = w_valid;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            demux_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk      (clk),
                .resetn   (resetn),
                .flush    (flush),
                .load     (w_load[gi]),
                .data_in  (in_data),
                .ready    (out_ready[gi]),
                .valid    (w_valid[gi]),
                .data_out (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
